dac_sweep_ctrl: RTL and testbench

Sequencer and configuration owner for the DDS waveform DAC path. It holds the host-written waveform, attenuation and frequency registers, and drives `dac_freq_poff`, `wave_sel` and `attenuation_sel` into the DAC block. It runs automatic frequency sweeps: linear steps of the phase increment, programmable dwell per step, optional bidirectional and looping modes. It sits between the register/command interface and the DAC generator.

---
 rtl/dac_ctrl_pkg.sv | 45 ++++
 rtl/sweep_dwell_timer.sv | 33 +++
 rtl/dac_sweep_ctrl.sv | 173 +++++++++++++++++
 tb/tb_dac_sweep_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_ctrl_pkg.sv
// Shared constants, state type and step helpers
// for the DDS sweep controller.
package dac_ctrl_pkg;

    localparam int DWELL_W_DEF = 24;

    localparam logic [2:0] ADDR_START = 3'd0;
    localparam logic [2:0] ADDR_STOP  = 3'd1;
    localparam logic [2:0] ADDR_STEP  = 3'd2;
    localparam logic [2:0] ADDR_DWELL = 3'd3;
    localparam logic [2:0] ADDR_WAVE  = 3'd4;
    localparam logic [2:0] ADDR_ATTEN = 3'd5;
    localparam logic [2:0] ADDR_MODE  = 3'd6;

    localparam int MODE_BIDIR = 0;
    localparam int MODE_LOOP  = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UP,
        ST_DOWN
    } sweep_state_e;

    // 33-bit arithmetic so the clamp sees overflow/underflow
    function automatic logic [31:0] step_up(
        input logic [31:0] c,
        input logic [31:0] s,
        input logic [31:0] lim
    );
        logic [32:0] t;
        t = {1'b0, c} + {1'b0, s};
        return (t > {1'b0, lim}) ? lim : t[31:0];
    endfunction

    function automatic logic [31:0] step_dn(
        input logic [31:0] c,
        input logic [31:0] s,
        input logic [31:0] lim
    );
        logic [32:0] t;
        t = {1'b0, c} - {1'b0, s};
        return (t[32] || t[31:0] < lim) ? lim : t[31:0];
    endfunction

endpackage

// File: rtl/sweep_dwell_timer.sv
// Loadable dwell down-counter; expire marks the last
// cycle of a dwell period.
module sweep_dwell_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         stop,
    input  logic [W-1:0] dwell,
    output logic         expire
);

    logic [W-1:0] cnt;
    logic         run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            run <= 1'b0;
        end else if (stop) begin
            run <= 1'b0;
        end else if (load) begin
            run <= 1'b1;
            cnt <= (dwell == '0) ? '0 : dwell - W'(1);
        end else if (run && cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = run && (cnt == '0);

endmodule

// File: rtl/dac_sweep_ctrl.sv
// DAC configuration registers and automatic
// linear frequency sweep sequencer.
module dac_sweep_ctrl
    import dac_ctrl_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic        start,
    input  logic        abort,
    output logic [31:0] dac_freq_poff,
    output logic [7:0]  wave_sel,
    output logic [7:0]  attenuation_sel,
    output logic        busy,
    output logic        step_strobe,
    output logic        sweep_done
);

    logic [31:0]        start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [1:0]         mode_r;

    logic [31:0]        snap_start, snap_stop, snap_step;
    logic [DWELL_W-1:0] snap_dwell;
    logic               snap_bidir, snap_loop;
    logic               init_up, outbound;
    sweep_state_e       state;

    logic [31:0]        e_start, e_stop, e_step;
    logic [DWELL_W-1:0] e_dwell;
    logic [1:0]         e_mode;
    logic               wr_start, run, go;

    logic [31:0]        target;
    logic               arrived, can_rev, finish;
    logic               expire, tmr_load, tmr_stop;
    logic [DWELL_W-1:0] tmr_dwell;

    assign wr_start = cfg_we && cfg_addr == ADDR_START;
    assign run      = state != ST_IDLE;
    assign go       = !run && start && !abort;

    // same-cycle writes are folded into the snapshot
    assign e_start = wr_start ? cfg_wdata : start_r;
    assign e_stop  = (cfg_we && cfg_addr == ADDR_STOP)
                   ? cfg_wdata : stop_r;
    assign e_step  = (cfg_we && cfg_addr == ADDR_STEP)
                   ? cfg_wdata : step_r;
    assign e_dwell = (cfg_we && cfg_addr == ADDR_DWELL)
                   ? cfg_wdata[DWELL_W-1:0] : dwell_r;
    assign e_mode  = (cfg_we && cfg_addr == ADDR_MODE)
                   ? cfg_wdata[1:0] : mode_r;

    assign target  = outbound ? snap_stop : snap_start;
    assign arrived = dac_freq_poff == target
                  || snap_step == '0;
    assign can_rev = snap_bidir && outbound
                  && snap_step != '0
                  && snap_start != snap_stop;
    assign finish  = arrived && !can_rev && !snap_loop;

    always_comb begin
        tmr_load  = go;
        tmr_stop  = 1'b0;
        tmr_dwell = run ? snap_dwell : e_dwell;
        if (run && abort) begin
            tmr_stop = 1'b1;
        end else if (run && expire) begin
            tmr_stop = finish;
            tmr_load = !finish;
        end
    end

    sweep_dwell_timer #(.W(DWELL_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (tmr_load),
        .stop   (tmr_stop),
        .dwell  (tmr_dwell),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_r         <= '0;
            stop_r          <= '0;
            step_r          <= '0;
            dwell_r         <= '0;
            mode_r          <= '0;
            wave_sel        <= '0;
            attenuation_sel <= '0;
            snap_start      <= '0;
            snap_stop       <= '0;
            snap_step       <= '0;
            snap_dwell      <= '0;
            snap_bidir      <= 1'b0;
            snap_loop       <= 1'b0;
            init_up         <= 1'b0;
            outbound        <= 1'b0;
            state           <= ST_IDLE;
            dac_freq_poff   <= '0;
            busy            <= 1'b0;
            step_strobe     <= 1'b0;
            sweep_done      <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            sweep_done  <= 1'b0;
            start_r     <= e_start;
            stop_r      <= e_stop;
            step_r      <= e_step;
            dwell_r     <= e_dwell;
            mode_r      <= e_mode;
            if (cfg_we && cfg_addr == ADDR_WAVE)
                wave_sel <= cfg_wdata[7:0];
            if (cfg_we && cfg_addr == ADDR_ATTEN)
                attenuation_sel <= cfg_wdata[7:0];
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        snap_start    <= e_start;
                        snap_stop     <= e_stop;
                        snap_step     <= e_step;
                        snap_dwell    <= e_dwell;
                        snap_bidir    <= e_mode[MODE_BIDIR];
                        snap_loop     <= e_mode[MODE_LOOP];
                        init_up       <= e_start <= e_stop;
                        outbound      <= 1'b1;
                        state         <= (e_start <= e_stop)
                                       ? ST_UP : ST_DOWN;
                        busy          <= 1'b1;
                        dac_freq_poff <= e_start;
                    end else if (wr_start) begin
                        dac_freq_poff <= cfg_wdata;
                    end
                end
                default: begin
                    if (abort) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (expire) begin
                        if (!arrived) begin
                            step_strobe   <= 1'b1;
                            dac_freq_poff <= (state == ST_UP)
                                ? step_up(dac_freq_poff, snap_step, target)
                                : step_dn(dac_freq_poff, snap_step, target);
                        end else if (can_rev) begin
                            step_strobe   <= 1'b1;
                            outbound      <= 1'b0;
                            state <= (state == ST_UP) ? ST_DOWN : ST_UP;
                            dac_freq_poff <= (state == ST_UP)
                                ? step_dn(dac_freq_poff, snap_step, snap_start)
                                : step_up(dac_freq_poff, snap_step, snap_start);
                        end else if (snap_loop) begin
                            step_strobe   <= 1'b1;
                            outbound      <= 1'b1;
                            state         <= init_up ? ST_UP : ST_DOWN;
                            dac_freq_poff <= snap_start;
                        end else begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            sweep_done <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dac_sweep_ctrl.sv
// Randomized and directed checks of dac_sweep_ctrl
// against a value-list model of the sweep.
module tb_dac_sweep_ctrl;
    import dac_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] dac_freq_poff;
    logic [7:0]  wave_sel, attenuation_sel;
    logic        busy, step_strobe, sweep_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_start = '0, m_stop = '0, m_step = '0;
    logic [31:0] m_dwell = '0;
    logic [1:0]  m_mode = '0;
    logic [31:0] vals[$];

    always #5 clk = ~clk;

    dac_sweep_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_we          (cfg_we),
        .cfg_addr        (cfg_addr),
        .cfg_wdata       (cfg_wdata),
        .start           (start),
        .abort           (abort),
        .dac_freq_poff   (dac_freq_poff),
        .wave_sel        (wave_sel),
        .attenuation_sel (attenuation_sel),
        .busy            (busy),
        .step_strobe     (step_strobe),
        .sweep_done      (sweep_done)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic void model_wr(input logic [2:0] a,
                                     input logic [31:0] d);
        case (a)
            ADDR_START: m_start = d;
            ADDR_STOP:  m_stop  = d;
            ADDR_STEP:  m_step  = d;
            ADDR_DWELL: m_dwell = {8'h0, d[23:0]};
            ADDR_MODE:  m_mode  = d[1:0];
            default: ;
        endcase
    endfunction

    task automatic write_reg(input logic [2:0] a,
                             input logic [31:0] d);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_addr = a;
        cfg_wdata = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
        model_wr(a, d);
    endtask

    task automatic load_regs(input logic [31:0] s, input logic [31:0] e,
                             input logic [31:0] st, input logic [31:0] dw,
                             input logic [1:0] md);
        write_reg(ADDR_START, s);
        write_reg(ADDR_STOP, e);
        write_reg(ADDR_STEP, st);
        write_reg(ADDR_DWELL, dw);
        write_reg(ADDR_MODE, {30'h0, md});
    endtask

    // list of distinct frequency values one pass visits
    task automatic build();
        longint c, s, e, st;
        s = longint'(m_start);
        e = longint'(m_stop);
        st = longint'(m_step);
        vals.delete();
        c = s;
        vals.push_back(c[31:0]);
        if (st != 0 && s != e) begin
            while (c != e) begin
                if (e > s) c = (c + st > e) ? e : c + st;
                else       c = (c - st < e) ? e : c - st;
                vals.push_back(c[31:0]);
            end
            if (m_mode[MODE_BIDIR]) begin
                while (c != s) begin
                    if (s > e) c = (c + st > s) ? s : c + st;
                    else       c = (c - st < s) ? s : c - st;
                    vals.push_back(c[31:0]);
                end
            end
        end
    endtask

    task automatic run_sweep(input int abort_at = -1,
                             input bit mid_wr = 1'b0,
                             input logic [31:0] new_stop = '0,
                             input bit same_st = 1'b0,
                             input logic [31:0] sv = '0);
        int d, len, ab;
        bit lp, aborted;
        logic [31:0] exp, held;
        @(negedge clk);
        if (same_st) begin
            cfg_we = 1'b1;
            cfg_addr = ADDR_START;
            cfg_wdata = sv;
            m_start = sv;
        end
        start = 1'b1;
        build();
        d = (m_dwell == 0) ? 1 : int'(m_dwell);
        len = vals.size() * d;
        lp = m_mode[MODE_LOOP];
        ab = abort_at;
        if (lp && ab < 0) ab = int'($urandom_range(0, 2 * len));
        aborted = 1'b0;
        held = '0;
        @(posedge clk);
        #1 start = 1'b0;
        cfg_we = 1'b0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (!lp && cyc == len) break;
            @(negedge clk);
            exp = vals[(cyc % len) / d];
            chk("poff", dac_freq_poff, exp);
            chk("busy", busy, 1);
            chk("strobe", step_strobe, (cyc % d == 0 && cyc != 0));
            chk("done", sweep_done, 0);
            if (mid_wr && cyc == 1) begin
                cfg_we = 1'b1;
                cfg_addr = ADDR_STOP;
                cfg_wdata = new_stop;
            end
            if (mid_wr && cyc == 2) start = 1'b1;
            if (cyc == ab) begin
                abort = 1'b1;
                held = exp;
                aborted = 1'b1;
            end
            if (cfg_we || abort || start) begin
                @(posedge clk);
                #1 cfg_we = 1'b0;
                abort = 1'b0;
                start = 1'b0;
            end
            if (aborted) break;
        end
        if (mid_wr) model_wr(ADDR_STOP, new_stop);
        @(negedge clk);
        chk("end_busy", busy, 0);
        chk("end_strobe", step_strobe, 0);
        if (aborted || lp) begin
            chk("abort_poff", dac_freq_poff, held);
            chk("abort_done", sweep_done, 0);
        end else begin
            chk("end_poff", dac_freq_poff, vals[$]);
            chk("end_done", sweep_done, 1);
        end
        @(negedge clk);
        chk("post_done", sweep_done, 0);
    endtask

    initial begin
        logic [31:0] base, held;
        repeat (3) @(negedge clk);
        chk("rst_poff", dac_freq_poff, 0);
        chk("rst_wave", wave_sel, 0);
        chk("rst_att", attenuation_sel, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobe", step_strobe, 0);
        chk("rst_done", sweep_done, 0);
        rst_n = 1'b1;

        write_reg(ADDR_WAVE, 32'h102);
        chk("wave", wave_sel, 8'h02);
        write_reg(ADDR_ATTEN, 32'h4);
        chk("atten", attenuation_sel, 8'h04);

        load_regs(100, 130, 10, 3, 2'b00);
        run_sweep();

        load_regs(100, 125, 10, 1, 2'b01);
        run_sweep();

        load_regs(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 0, 2'b00);
        run_sweep();

        load_regs(100, 120, 10, 2, 2'b10);
        run_sweep(8);

        held = dac_freq_poff;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("sa_busy", busy, 0);
        chk("sa_poff", dac_freq_poff, held);

        load_regs(100, 130, 10, 2, 2'b00);
        run_sweep(-1, 1'b1, 150);
        run_sweep();

        run_sweep(-1, 1'b0, '0, 1'b1, 32'd90);

        load_regs(200, 170, 0, 2, 2'b11);
        run_sweep(5);

        write_reg(ADDR_START, 32'h1234);
        chk("manual", dac_freq_poff, 32'h1234);

        for (int i = 0; i < 12; i++) begin
            base = $urandom_range(0, 32'hFFFF_FE00);
            load_regs(base + $urandom_range(0, 200),
                      base + $urandom_range(0, 200),
                      $urandom_range(0, 40),
                      $urandom_range(0, 4),
                      2'($urandom_range(0, 3)));
            write_reg(ADDR_WAVE, $urandom);
            run_sweep();
            base = $urandom;
            write_reg(ADDR_START, base);
            chk("rnd_manual", dac_freq_poff, base);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
